frog_ctrl: RTL and testbench

FROG_CTRL -- requirements
Module: frog_ctrl

---
 rtl/frog_pkg.sv | 15 +
 rtl/frog_ctrl_edge_detect.sv | 21 ++
 rtl/frog_ctrl.sv | 120 ++++++++++++
 tb/tb_frog_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// Shared types and sizing for the frog controller: grid dimension, coordinate type, FSM states.
package frog_pkg;

  localparam int unsigned GRID_DIM = 16;
  localparam int unsigned COORD_W  = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    DEAD   = 2'd1,
    FROZEN = 2'd2
  } state_t;

endpackage

// File: rtl/frog_ctrl_edge_detect.sv
// One-bit rising-edge detector; history register samples every cycle regardless of game state.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic rise_c
);

  logic prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_c = sig_i & ~prev_q;

endmodule

// File: rtl/frog_ctrl.sv
// Frog position/lifecycle controller: button moves, collision dwell, goal scoring, game-over freeze.
module frog_ctrl
  import frog_pkg::*;
#(
  parameter coord_t      START_ROW      = 4'd15,
  parameter coord_t      START_COL      = 4'd7,
  parameter coord_t      GOAL_ROW       = 4'd0,
  parameter int unsigned RESPAWN_CYCLES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                up,
  input  logic                down,
  input  logic                left,
  input  logic                right,
  input  logic [GRID_DIM-1:0] row_hazard,
  input  logic                game_over,
  output logic [COORD_W-1:0]  frog_row,
  output logic [COORD_W-1:0]  frog_col,
  output logic                win,
  output logic                lose
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(RESPAWN_CYCLES - 1);
  localparam coord_t EDGE_MAX = COORD_W'(GRID_DIM - 1);

  state_t          state_q, state_d;
  coord_t          row_q, row_d, col_q, col_d;
  coord_t          mv_row, mv_col;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            win_q, win_d, lose_q, lose_d;
  logic            up_rise, down_rise, left_rise, right_rise;

  edge_detect u_ed_up    (.clock(clock), .reset(reset), .sig_i(up),    .rise_c(up_rise));
  edge_detect u_ed_down  (.clock(clock), .reset(reset), .sig_i(down),  .rise_c(down_rise));
  edge_detect u_ed_left  (.clock(clock), .reset(reset), .sig_i(left),  .rise_c(left_rise));
  edge_detect u_ed_right (.clock(clock), .reset(reset), .sig_i(right), .rise_c(right_rise));

  // Candidate move: only the highest-priority edge acts, even if it is blocked by the border.
  always_comb begin
    mv_row = row_q;
    mv_col = col_q;
    if (up_rise) begin
      if (row_q != '0) mv_row = row_q - COORD_W'(1);
    end else if (down_rise) begin
      if (row_q != EDGE_MAX) mv_row = row_q + COORD_W'(1);
    end else if (left_rise) begin
      if (col_q != '0) mv_col = col_q - COORD_W'(1);
    end else if (right_rise) begin
      if (col_q != EDGE_MAX) mv_col = col_q + COORD_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    win_d   = 1'b0;
    lose_d  = 1'b0;
    if (game_over) begin
      state_d = FROZEN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (row_hazard[col_q]) begin
            lose_d  = 1'b1;
            state_d = DEAD;
            cnt_d   = '0;
          end else if (row_q == GOAL_ROW) begin
            win_d = 1'b1;
            row_d = START_ROW;
            col_d = START_COL;
          end else begin
            row_d = mv_row;
            col_d = mv_col;
          end
        end
        DEAD: begin
          if (cnt_q == CNT_TERM) begin
            state_d = PLAY;
            cnt_d   = '0;
            row_d   = START_ROW;
            col_d   = START_COL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FROZEN: state_d = FROZEN;
        default: state_d = PLAY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PLAY;
      row_q   <= START_ROW;
      col_q   <= START_COL;
      cnt_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign frog_row = row_q;
  assign frog_col = col_q;
  assign win      = win_q;
  assign lose     = lose_q;

endmodule

// File: tb/tb_frog_ctrl.sv
// Scoreboard bench for frog_ctrl: stimulus pushes expected outputs, a monitor pops and compares.
module tb_frog_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        up, down, left, right;
  logic [15:0] row_hazard;
  logic        game_over;
  logic [3:0]  frog_row, frog_col;
  logic        win, lose;

  localparam logic [3:0] BN = 4'b0000;
  localparam logic [3:0] BU = 4'b1000;
  localparam logic [3:0] BD = 4'b0100;
  localparam logic [3:0] BL = 4'b0010;
  localparam logic [3:0] BR = 4'b0001;

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic       win;
    logic       lose;
    int         tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;
  event sample_now;

  frog_ctrl dut (
    .clock(clock), .reset(reset),
    .up(up), .down(down), .left(left), .right(right),
    .row_hazard(row_hazard), .game_over(game_over),
    .frog_row(frog_row), .frog_col(frog_col),
    .win(win), .lose(lose)
  );

  always #5 clock = ~clock;

  task automatic push_exp(input logic [3:0] er, input logic [3:0] ec,
                          input logic ew, input logic el);
    exp_t e;
    e.row = er; e.col = ec; e.win = ew; e.lose = el; e.tag = step_id;
    step_id++;
    sb_q.push_back(e);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input logic [3:0] btn, input logic [15:0] haz, input logic go,
                     input logic [3:0] er, input logic [3:0] ec,
                     input logic ew, input logic el);
    {up, down, left, right} = btn;
    row_hazard = haz;
    game_over  = go;
    @(posedge clock);
    push_exp(er, ec, ew, el);
    @(negedge clock);
  endtask

  task automatic press(input logic [3:0] btn, input logic [3:0] er, input logic [3:0] ec);
    cyc(btn, 16'h0, 1'b0, er, ec, 1'b0, 1'b0);
    cyc(BN,  16'h0, 1'b0, er, ec, 1'b0, 1'b0);
  endtask

  // Assert reset between clock edges and check outputs before any edge arrives.
  task automatic reset_check(input logic [3:0] btn);
    #1;
    reset = 1'b1;
    {up, down, left, right} = btn;
    row_hazard = 16'h0;
    game_over  = 1'b0;
    #1;
    push_exp(4'd15, 4'd7, 1'b0, 1'b0);
    -> sample_now;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clock or sample_now);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_checks++;
        if (frog_row === e.row && frog_col === e.col && win === e.win && lose === e.lose) begin
          n_pass++;
        end else begin
          $display("FAIL step%0d row/col/win/lose got %0d/%0d/%b/%b exp %0d/%0d/%b/%b",
                   e.tag, frog_row, frog_col, win, lose, e.row, e.col, e.win, e.lose);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    {up, down, left, right} = BN;
    row_hazard = 16'h0;
    game_over  = 1'b0;
    repeat (2) @(negedge clock);
    reset_check(BN);

    // Held up moves once.
    repeat (20) cyc(BU, 16'h0, 1'b0, 4'd14, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0, 1'b0, 4'd14, 4'd7, 1'b0, 1'b0);

    // Climb to the goal; a down pressed on the win edge is discarded.
    for (int r = 13; r >= 0; r--) begin
      cyc(BU, 16'h0, 1'b0, 4'(r), 4'd7, 1'b0, 1'b0);
      if (r != 0) cyc(BN, 16'h0, 1'b0, 4'(r), 4'd7, 1'b0, 1'b0);
    end
    cyc(BD, 16'h0, 1'b0, 4'd15, 4'd7, 1'b1, 1'b0);
    cyc(BN, 16'h0, 1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    press(BD, 4'd15, 4'd7);

    // Collision and 8-cycle dwell; buttons and hazards ignored, held button no move on exit.
    cyc(BN, 16'h0080, 1'b0, 4'd15, 4'd7, 1'b0, 1'b1);
    cyc(BU, 16'h0,    1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0,    1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BL, 16'h0,    1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0080, 1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0,    1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0,    1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BR, 16'h0,    1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BR, 16'h0,    1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BR, 16'h0,    1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BU, 16'h0,    1'b0, 4'd14, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0,    1'b0, 4'd14, 4'd7, 1'b0, 1'b0);

    // Walk to (10,3), then priority and border cases.
    for (int r = 13; r >= 10; r--) press(BU, 4'(r), 4'd7);
    for (int c = 6; c >= 3; c--) press(BL, 4'd10, 4'(c));
    cyc(BU | BL, 16'h0, 1'b0, 4'd9, 4'd3, 1'b0, 1'b0);
    cyc(BN,      16'h0, 1'b0, 4'd9, 4'd3, 1'b0, 1'b0);
    for (int c = 2; c >= 0; c--) press(BL, 4'd9, 4'(c));
    press(BL, 4'd9, 4'd0);
    press(BR, 4'd9, 4'd1);
    cyc(BD | BR, 16'h0, 1'b0, 4'd10, 4'd1, 1'b0, 1'b0);
    cyc(BN,      16'h0, 1'b0, 4'd10, 4'd1, 1'b0, 1'b0);
    cyc(BL | BR, 16'h0, 1'b0, 4'd10, 4'd0, 1'b0, 1'b0);
    cyc(BN,      16'h0, 1'b0, 4'd10, 4'd0, 1'b0, 1'b0);
    press(BR, 4'd10, 4'd1);

    // Game over beats a coincident collision; frozen until reset.
    cyc(BN, 16'h0002, 1'b1, 4'd10, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      cyc((i % 4 == 0) ? BU : ((i % 4 == 2) ? BR : BN), 16'hFFFF, 1'b0,
          4'd10, 4'd1, 1'b0, 1'b0);
    end
    reset_check(BU);
    cyc(BU, 16'h0, 1'b0, 4'd14, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0, 1'b0, 4'd14, 4'd7, 1'b0, 1'b0);

    // Reset mid-dwell, then a full-length dwell proves the counter restarted.
    cyc(BN, 16'h0080, 1'b0, 4'd14, 4'd7, 1'b0, 1'b1);
    repeat (3) cyc(BN, 16'h0, 1'b0, 4'd14, 4'd7, 1'b0, 1'b0);
    reset_check(BN);
    cyc(BN, 16'h0080, 1'b0, 4'd15, 4'd7, 1'b0, 1'b1);
    repeat (5) cyc(BN, 16'h0, 1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BU, 16'h0, 1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0, 1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0, 1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BU, 16'h0, 1'b0, 4'd14, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0, 1'b0, 4'd14, 4'd7, 1'b0, 1'b0);

    // Hazard at the goal row: collision only, then respawn from the goal row.
    for (int r = 13; r >= 0; r--) begin
      cyc(BU, 16'h0, 1'b0, 4'(r), 4'd7, 1'b0, 1'b0);
      if (r != 0) cyc(BN, 16'h0, 1'b0, 4'(r), 4'd7, 1'b0, 1'b0);
    end
    cyc(BN, 16'h0080, 1'b0, 4'd0, 4'd7, 1'b0, 1'b1);
    repeat (7) cyc(BN, 16'h0, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0, 1'b0, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc(BN, 16'h0, 1'b0, 4'd15, 4'd7, 1'b0, 1'b0);

    repeat (3) @(negedge clock);
    #1;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
